// File: rtl/bundle_unpacker_pkg.sv
// Shared core package: slot geometry, PC step and unpacker state encoding.
package bundle_unpacker_pkg;

    localparam int SLOT_W   = 32;
    localparam int SLOTS    = 4;
    localparam int BUNDLE_W = SLOT_W * SLOTS;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF0 = 2'd1,
        HALF1 = 2'd2
    } unpack_state_e;

    // First half that has work in a freshly accepted bundle.
    function automatic unpack_state_e entry_state(input logic [SLOTS-1:0] m);
        if (|m[1:0]) begin
            return HALF0;
        end else if (|m[3:2]) begin
            return HALF1;
        end
        return EMPTY;
    endfunction

endpackage

// File: rtl/bundle_lane_select.sv
// Two-slot compaction onto issue lanes plus slot PC generation.
module bundle_lane_select
    import bundle_unpacker_pkg::*;
(
    input  logic              en_i,
    input  logic              half_i,
    input  logic [SLOT_W-1:0] slot_lo_i,
    input  logic [SLOT_W-1:0] slot_hi_i,
    input  logic [1:0]        mask_i,
    input  logic [31:0]       base_pc_i,
    output logic [SLOT_W-1:0] inst0_o,
    output logic [SLOT_W-1:0] inst1_o,
    output logic [31:0]       pc0_o,
    output logic [31:0]       pc1_o,
    output logic              inst0_valid_o,
    output logic              inst1_valid_o
);

    logic [31:0] pc_lo;
    logic [31:0] pc_hi;

    // Upper half starts two slots past the bundle PC; wraps mod 2^32.
    assign pc_lo = base_pc_i + (half_i ? (PC_STEP << 1) : 32'd0);
    assign pc_hi = pc_lo + PC_STEP;

    always_comb begin
        inst0_o       = '0;
        inst1_o       = '0;
        pc0_o         = '0;
        pc1_o         = '0;
        inst0_valid_o = 1'b0;
        inst1_valid_o = 1'b0;
        if (en_i) begin
            if (mask_i[0]) begin
                inst0_o       = slot_lo_i;
                pc0_o         = pc_lo;
                inst0_valid_o = 1'b1;
                if (mask_i[1]) begin
                    inst1_o       = slot_hi_i;
                    pc1_o         = pc_hi;
                    inst1_valid_o = 1'b1;
                end
            end else if (mask_i[1]) begin
                inst0_o       = slot_hi_i;
                pc0_o         = pc_hi;
                inst0_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bundle_unpacker.sv
// Holds one fetch bundle and issues it as two halves onto two decode lanes.
module bundle_unpacker
    import bundle_unpacker_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [BUNDLE_W-1:0] bundle_in,
    input  logic [31:0]         bundle_pc,
    input  logic [SLOTS-1:0]    bundle_mask,
    input  logic                bundle_valid,
    output logic                bundle_ready,
    input  logic                stall,
    output logic [SLOT_W-1:0]   inst0,
    output logic [SLOT_W-1:0]   inst1,
    output logic [31:0]         pc0,
    output logic [31:0]         pc1,
    output logic                inst0_valid,
    output logic                inst1_valid
);

    unpack_state_e       state_q, state_d;
    logic [BUNDLE_W-1:0] data_q, data_d;
    logic [31:0]         pc_q, pc_d;
    logic [SLOTS-1:0]    mask_q, mask_d;
    logic                xfer;
    logic                half;

    assign bundle_ready = !rst && !flush &&
        (state_q == EMPTY || (state_q == HALF1 && !stall));
    assign xfer = bundle_valid && bundle_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (xfer) begin
            state_d = entry_state(bundle_mask);
            data_d  = bundle_in;
            pc_d    = bundle_pc;
            mask_d  = bundle_mask;
        end else if (!stall) begin
            // HALF0 with an empty upper half retires the bundle at once.
            case (state_q)
                HALF0:   state_d = (|mask_q[3:2]) ? HALF1 : EMPTY;
                HALF1:   state_d = EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            pc_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
        end
    end

    assign half = (state_q == HALF1);

    bundle_lane_select u_lane_select (
        .en_i          (state_q != EMPTY),
        .half_i        (half),
        .slot_lo_i     (half ? data_q[95:64]  : data_q[31:0]),
        .slot_hi_i     (half ? data_q[127:96] : data_q[63:32]),
        .mask_i        (half ? mask_q[3:2]    : mask_q[1:0]),
        .base_pc_i     (pc_q),
        .inst0_o       (inst0),
        .inst1_o       (inst1),
        .pc0_o         (pc0),
        .pc1_o         (pc1),
        .inst0_valid_o (inst0_valid),
        .inst1_valid_o (inst1_valid)
    );

endmodule
